// File: rtl/spi_tx_queue.sv
// SPI transmit descriptor queue: buffers {cpol, cpha, byte} descriptors and
// hands them one at a time to a downstream SPI master, holding each issued
// descriptor stable for GAP cycles after a single-cycle start pulse.
module spi_tx_queue #(
  parameter int DEPTH = 4,
  parameter int GAP   = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_dat,
  input  logic       wr_cpol,
  input  logic       wr_cpha,
  output logic       wr_ready,
  output logic       start,
  output logic [7:0] p_dat,
  output logic       cpol,
  output logic       cpha,
  output logic       busy,
  output logic [4:0] level,
  output logic       ovf
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [9:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [4:0]      r_level;
  logic [7:0]      r_cnt;
  logic [7:0]      r_p_dat;
  logic            r_cpol;
  logic            r_cpha;
  logic            r_ovf;
  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_start;
  logic [9:0]      w_head;

  // Queue handshake: full/empty decisions use registered level only.
  assign w_ready = (r_level != 5'(DEPTH));
  assign w_push  = wr_en && w_ready;
  assign w_pop   = (r_state == S_IDLE) && (r_level != 5'd0);
  assign w_head  = r_mem[r_rd_ptr];

  // Descriptor storage; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= {wr_cpol, wr_cpha, wr_dat};
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 5'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase
      if (wr_en && !w_ready) r_ovf <= 1'b1;
    end
  end

  // Issued descriptor: changes only when the head entry is popped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p_dat <= 8'h00;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
    end else if (w_pop) begin
      r_cpol  <= w_head[9];
      r_cpha  <= w_head[8];
      r_p_dat <= w_head[7:0];
    end
  end

  // FSM state register and hold-window counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_START) begin
        r_cnt <= 8'(GAP);
      end else if (r_state == S_HOLD) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  // FSM next-state: issue when something is queued, then hold GAP cycles.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_next_state = S_START;
      S_START: w_next_state = S_HOLD;
      S_HOLD:  if (r_cnt == 8'd1) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: start pulse exists only in the START state.
  always_comb begin
    w_start = 1'b0;
    if (r_state == S_START) w_start = 1'b1;
  end

  assign wr_ready = w_ready;
  assign start    = w_start;
  assign p_dat    = r_p_dat;
  assign cpol     = r_cpol;
  assign cpha     = r_cpha;
  assign busy     = (r_state != S_IDLE) || (r_level != 5'd0);
  assign level    = r_level;
  assign ovf      = r_ovf;

endmodule
